// File: rtl/gmii_tx_arbiter_pkg.sv
// Shared types and sizing helpers for the GMII transmit arbiter.
// State encoding, default parameter values and counter-width functions live here.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XMIT  = 2'd2,
        ST_IFG   = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_IFG_CYCLES  = 12;
    localparam int DEF_GNT_TIMEOUT = 64;
    localparam int DEF_MAX_FRAME   = 1530;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gmii_tx_arbiter_if.sv
// Request/grant and per-source GMII bundle between frame sources and the arbiter.
// master = the sources side, slave = the arbiter.
interface gmii_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   src_tx_en;
    logic [8*NUM_REQ-1:0] src_txd;
    logic                 gmii_tx_en;
    logic [7:0]           gmii_txd;
    logic                 busy;
    logic                 trunc_pulse;

    modport master (
        output req, src_tx_en, src_txd,
        input  gnt, gmii_tx_en, gmii_txd, busy, trunc_pulse
    );

    modport slave (
        input  req, src_tx_en, src_txd,
        output gnt, gmii_tx_en, gmii_txd, busy, trunc_pulse
    );

endinterface

// File: rtl/gmii_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_rr_ptr, wrapping.
// o_valid is low when no request is pending.
module rr_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_winner
);

    localparam logic [IDX_W:0] NUM_REQ_V = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // NOTE: every output and temporary gets a default before the loop, so no path infers a latch.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, i_rr_ptr} + (IDX_W + 1)'(i);
            if (w_sum >= NUM_REQ_V) begin
                w_sum = w_sum - NUM_REQ_V;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!o_valid && i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Shares one GMII transmit path between NUM_REQ frame sources: per-frame round-robin grant,
// registered byte mux, forced inter-frame gap, grant timeout and oversize truncation.
module gmii_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int IFG_CYCLES  = DEF_IFG_CYCLES,
    parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
    parameter int MAX_FRAME   = DEF_MAX_FRAME
) (
    input  logic             gmii_tx_clk,
    input  logic             rst,
    gmii_tx_arbiter_if.slave io_bus
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int BYTE_W = cnt_width(MAX_FRAME);
    localparam int WAIT_W = cnt_width(GNT_TIMEOUT);
    localparam int IFG_W  = cnt_width(IFG_CYCLES);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(MAX_FRAME);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GNT_TIMEOUT - 1);
    localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_CYCLES - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_tx_en;
    logic [7:0]         r_txd;
    logic               r_trunc;
    logic [BYTE_W-1:0]  r_byte_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [IFG_W-1:0]   r_ifg_cnt;

    logic               w_arb_valid;
    logic [IDX_W-1:0]   w_arb_winner;
    logic               w_sel_en;
    logic [7:0]         w_sel_txd;
    logic               w_fwd;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic               w_tx_en_nxt;
    logic [7:0]         w_txd_nxt;
    logic               w_trunc_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req    (io_bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_arb_valid),
        .o_winner (w_arb_winner)
    );

    // Only the granted source's lane is ever looked at; the others cannot reach GMII.
    always_comb begin
        w_sel_en  = 1'b0;
        w_sel_txd = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_sel == IDX_W'(i)) begin
                w_sel_en  = io_bus.src_tx_en[i];
                w_sel_txd = io_bus.src_txd[8*i +: 8];
            end
        end
    end

    // A byte is forwarded in XMIT only while the frame is still under the size limit.
    assign w_fwd = w_sel_en && (r_byte_cnt != BYTE_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) w_state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                if (w_sel_en)                       w_state_nxt = ST_XMIT;
                else if (r_wait_cnt == WAIT_LAST)   w_state_nxt = ST_IDLE;
            end
            ST_XMIT: begin
                if (!w_fwd) w_state_nxt = ST_IFG;
            end
            ST_IFG: begin
                if (r_ifg_cnt == IFG_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; GMII is idle unless a byte is forwarded.
    always_comb begin
        w_gnt_nxt   = r_gnt;
        w_tx_en_nxt = 1'b0;
        w_txd_nxt   = 8'h00;
        w_trunc_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) w_gnt_nxt = NUM_REQ'(1) << w_arb_winner;
            end
            ST_GRANT: begin
                if (w_sel_en) begin
                    w_tx_en_nxt = 1'b1;
                    w_txd_nxt   = w_sel_txd;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_gnt_nxt = '0;
                end
            end
            ST_XMIT: begin
                if (w_fwd) begin
                    w_tx_en_nxt = 1'b1;
                    w_txd_nxt   = w_sel_txd;
                end else begin
                    w_gnt_nxt   = '0;
                    w_trunc_nxt = w_sel_en;
                end
            end
            default: w_gnt_nxt = '0;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            r_gnt    <= '0;
            r_tx_en  <= 1'b0;
            r_txd    <= 8'h00;
            r_trunc  <= 1'b0;
            r_rr_ptr <= '0;
            r_sel    <= '0;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_tx_en <= w_tx_en_nxt;
            r_txd   <= w_txd_nxt;
            r_trunc <= w_trunc_nxt;
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_sel    <= w_arb_winner;
                r_rr_ptr <= (w_arb_winner == IDX_LAST) ? '0 : w_arb_winner + IDX_W'(1);
            end
        end
    end

    // Byte count starts at 1 because the GRANT->XMIT edge already forwards the first byte.
    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_wait_cnt <= '0;
            r_ifg_cnt  <= '0;
        end else begin
            r_wait_cnt <= (r_state == ST_GRANT) ? r_wait_cnt + WAIT_W'(1) : '0;
            r_ifg_cnt  <= (r_state == ST_IFG)   ? r_ifg_cnt + IFG_W'(1)   : '0;
            if (r_state == ST_GRANT && w_sel_en) begin
                r_byte_cnt <= BYTE_W'(1);
            end else if (r_state == ST_XMIT && w_fwd) begin
                r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
            end
        end
    end

    assign io_bus.gnt         = r_gnt;
    assign io_bus.gmii_tx_en  = r_tx_en;
    assign io_bus.gmii_txd    = r_txd;
    assign io_bus.trunc_pulse = r_trunc;
    assign io_bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: stimulus queues expected GMII bytes and grant order,
// an independent negedge monitor pops and compares them and gathers burst/gap/IFG statistics.
module tb_gmii_tx_arbiter;
    import eth_tx_arb_pkg::*;

    localparam int NUM_REQ     = 2;
    localparam int IFG_CYCLES  = 12;
    localparam int GNT_TIMEOUT = 64;
    localparam int MAX_FRAME   = 1530;

    logic clk = 1'b0;
    logic rst;

    gmii_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    gmii_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .IFG_CYCLES  (IFG_CYCLES),
        .GNT_TIMEOUT (GNT_TIMEOUT),
        .MAX_FRAME   (MAX_FRAME)
    ) dut (
        .gmii_tx_clk (clk),
        .rst         (rst),
        .io_bus      (bus)
    );

    always #4 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         gnt_q[$];
    int         trunc_cnt   = 0;
    int         last_len    = 0;
    int         last_ifg    = 0;
    int         min_gap     = 1000000;
    int         txd_nonzero = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int src, input int i);
        return 8'((i * 13 + src * 100 + 7) & 255);
    endfunction

    task automatic wait_gnt(input int src);
        for (int n = 0; n < 300 && !bus.gnt[src]; n++) begin
            @(posedge clk); #1;
        end
        check("wait_gnt", 32'(bus.gnt[src]), 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000 && bus.busy; n++) begin
            @(posedge clk); #1;
        end
        check("wait_idle", 32'(bus.busy), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // Called one step after the edge that raised gnt[src]; drives len bytes, expects the first keep.
    task automatic send_frame(input int src, input int len, input int keep, input bit noise);
        for (int i = 0; i < len; i++) begin
            bus.src_tx_en[src]       = 1'b1;
            bus.src_txd[8*src +: 8]  = frame_byte(src, i);
            if (i < keep) exp_q.push_back(frame_byte(src, i));
            if (noise) begin
                bus.src_tx_en[1]  = ((i % 2) == 1);
                bus.src_txd[15:8] = 8'(8'hA5 ^ i);
            end
            @(posedge clk); #1;
        end
        bus.src_tx_en = '0;
        bus.src_txd   = '0;
    endtask

    initial begin : monitor
        bit         prev_en;
        bit         counting;
        bit         seen_burst;
        int         cur_len;
        int         low_cnt;
        int         ifg_cnt;
        logic [1:0] prev_gnt;
        prev_en = 0; counting = 0; seen_burst = 0;
        cur_len = 0; low_cnt = 0; ifg_cnt = 0; prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 0; counting = 0; seen_burst = 0;
                cur_len = 0; low_cnt = 0; prev_gnt = '0;
            end else begin
                if (prev_gnt == 2'b00 && bus.gnt != 2'b00) begin
                    if (gnt_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL gnt_order: got %0b expected no grant", bus.gnt);
                    end else begin
                        int e;
                        e = gnt_q.pop_front();
                        check("gnt_order", 32'(bus.gnt), 32'(1) << e);
                    end
                end
                if (bus.gmii_tx_en) begin
                    if (!prev_en) begin
                        if (seen_burst && low_cnt < min_gap) min_gap = low_cnt;
                        cur_len = 0;
                    end
                    cur_len++;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL gmii_byte: got %0h expected no byte", bus.gmii_txd);
                    end else begin
                        check("gmii_byte", 32'(bus.gmii_txd), 32'(exp_q.pop_front()));
                    end
                end else begin
                    if (bus.gmii_txd != 8'h00) txd_nonzero++;
                    if (prev_en) begin
                        last_len   = cur_len;
                        seen_burst = 1;
                        low_cnt    = 0;
                        counting   = 1;
                        ifg_cnt    = 0;
                    end
                    low_cnt++;
                    if (counting) begin
                        if (bus.busy) begin
                            ifg_cnt++;
                        end else begin
                            last_ifg = ifg_cnt;
                            counting = 0;
                        end
                    end
                end
                if (bus.trunc_pulse) trunc_cnt++;
                prev_en  = bus.gmii_tx_en;
                prev_gnt = bus.gnt;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        int s;
        rst           = 1'b1;
        bus.req       = '0;
        bus.src_tx_en = '0;
        bus.src_txd   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt",   32'(bus.gnt),         32'd0);
        check("rst_tx_en", 32'(bus.gmii_tx_en),  32'd0);
        check("rst_txd",   32'(bus.gmii_txd),    32'd0);
        check("rst_busy",  32'(bus.busy),        32'd0);
        check("rst_trunc", 32'(bus.trunc_pulse), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single source, 64-byte frame, grant one cycle after request, 12-cycle IFG.
        gnt_q.push_back(0);
        bus.req = 2'b01;
        @(posedge clk); #1;
        check("t1_gnt_latency", 32'(bus.gnt), 32'b01);
        bus.req = 2'b00;
        send_frame(0, 64, 64, 0);
        wait_idle();
        check("t1_len", 32'(last_len), 32'd64);
        check("t1_ifg", 32'(last_ifg), 32'(IFG_CYCLES));

        // Granted source never transmits: grant revoked after GNT_TIMEOUT cycles.
        gnt_q.push_back(1);
        bus.req = 2'b10;
        wait_gnt(1);
        bus.req = 2'b00;
        n = 0;
        while (bus.gnt[1] && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check("t3_timeout_cycles", 32'(n), 32'(GNT_TIMEOUT));
        check("t3_busy", 32'(bus.busy), 32'd0);
        gnt_q.push_back(1);
        bus.req = 2'b10;
        wait_gnt(1);
        bus.req = 2'b00;
        send_frame(1, 8, 8, 0);
        wait_idle();

        // Both requests held: grants alternate 0,1,0,1 with the minimum 14-cycle gap.
        for (int k = 0; k < 4; k++) gnt_q.push_back(k % 2);
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            s = k % 2;
            wait_gnt(s);
            if (k == 3) bus.req = 2'b00;
            send_frame(s, 16 + k, 16 + k, 0);
        end
        wait_idle();
        check("t2_min_gap", 32'(min_gap), 32'(IFG_CYCLES + 2));

        // Oversize frame truncated at MAX_FRAME.
        gnt_q.push_back(0);
        bus.req = 2'b01;
        wait_gnt(0);
        bus.req = 2'b00;
        send_frame(0, 2000, MAX_FRAME, 0);
        wait_idle();
        check("t4_len",   32'(last_len),  32'(MAX_FRAME));
        check("t4_trunc", 32'(trunc_cnt), 32'd1);
        check("t4_ifg",   32'(last_ifg),  32'(IFG_CYCLES));

        // Source 1 toggles its lane while source 0 owns the grant.
        gnt_q.push_back(0);
        bus.req = 2'b01;
        wait_gnt(0);
        bus.req = 2'b00;
        send_frame(0, 32, 32, 1);
        wait_idle();
        check("t5_txd_zero_when_idle", 32'(txd_nonzero), 32'd0);

        // Reset mid-frame drops outputs without a clock edge and clears the round-robin pointer.
        gnt_q.push_back(0);
        bus.req = 2'b01;
        wait_gnt(0);
        bus.req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            bus.src_tx_en[0] = 1'b1;
            bus.src_txd[7:0] = frame_byte(0, i);
            exp_q.push_back(frame_byte(0, i));
            @(posedge clk); #1;
        end
        check("t6_pre_tx_en", 32'(bus.gmii_tx_en), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_rst_tx_en", 32'(bus.gmii_tx_en), 32'd0);
        check("t6_rst_txd",   32'(bus.gmii_txd),   32'd0);
        check("t6_rst_gnt",   32'(bus.gnt),        32'd0);
        check("t6_rst_busy",  32'(bus.busy),       32'd0);
        bus.src_tx_en = '0;
        bus.src_txd   = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        gnt_q.push_back(0);
        bus.req = 2'b11;
        @(posedge clk); #1;
        check("t6_gnt_after_rst", 32'(bus.gnt), 32'b01);
        bus.req = 2'b00;
        send_frame(0, 10, 10, 0);
        wait_idle();

        check("exp_bytes_left",  32'(exp_q.size()), 32'd0);
        check("exp_grants_left", 32'(gnt_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
